// File: rtl/stream_to_axi_r.sv
// stream_to_axi_r: turns header-framed stream packets into AXI read-data beats.
// A header carrying the accepted type opens a packet whose payload beats are
// forwarded as R beats under the header's rid; foreign packets are discarded
// and counted. R beats pass through a 2-entry FIFO so that s_ready depends
// only on registered state and never on AXIM_rready.
module stream_to_axi_r #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH = 32,
  parameter int USER_WIDTH = 64,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic [ID_WIDTH-1:0]   AXIM_rid,
  output logic [DATA_WIDTH-1:0] AXIM_rdata,
  output logic [1:0]            AXIM_rresp,
  output logic                  AXIM_rlast,
  output logic [USER_WIDTH-1:0] AXIM_ruser,
  output logic                  AXIM_rvalid,
  input  logic                  AXIM_rready,
  output logic                  in_progress,
  output logic                  pkt_dropped,
  output logic [15:0]           drop_count
);

  localparam int ENTRY_W = ID_WIDTH + DATA_WIDTH + 3;

  typedef enum logic [1:0] {HDR, DATA, DROP} state_t;

  state_t                       state_reg, state_next;
  logic [ID_WIDTH-1:0]          rid_reg;
  logic                         ready_en_reg;
  logic [1:0]                   count_reg;
  logic                         wr_ptr_reg, rd_ptr_reg;
  logic [ENTRY_W-1:0]           fifo_mem [2];
  logic                         pkt_dropped_reg;
  logic [15:0]                  drop_count_reg;

  logic                         accept, pop, push, drop_done, type_match;
  logic [ENTRY_W-1:0]           push_entry;
  logic [STREAM_TYPE_WIDTH-1:0] hdr_type;
  logic [ID_WIDTH-1:0]          hdr_rid;

  // Header fields: type sits in the top bits, rid in the bottom bits.
  assign hdr_type   = s_data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH];
  assign hdr_rid    = s_data[ID_WIDTH-1:0];
  assign type_match = (hdr_type == STREAM_TYPE);

  // ready_en_reg holds s_ready low until the first edge after reset.
  assign s_ready = ready_en_reg && (count_reg != 2'd2);
  assign accept  = s_valid && s_ready;
  assign pop     = (count_reg != 2'd0) && AXIM_rready;

  // Next-state decode and R beat generation for each accepted stream beat.
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    push_entry = '0;
    drop_done  = 1'b0;
    case (state_reg)
      HDR: begin
        if (accept) begin
          if (type_match) begin
            if (s_last) begin
              // Header-only packet: report it as an error beat with no data.
              push       = 1'b1;
              push_entry = {hdr_rid, {DATA_WIDTH{1'b0}}, 2'b10, 1'b1};
            end else begin
              state_next = DATA;
            end
          end else if (s_last) begin
            drop_done = 1'b1;
          end else begin
            state_next = DROP;
          end
        end
      end
      DATA: begin
        if (accept) begin
          push       = 1'b1;
          push_entry = {rid_reg, s_data, 2'b00, s_last};
          if (s_last) state_next = HDR;
        end
      end
      DROP: begin
        if (accept && s_last) begin
          drop_done  = 1'b1;
          state_next = HDR;
        end
      end
      default: state_next = HDR;
    endcase
  end

  // State register, header rid latch and the post-reset ready enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= HDR;
      rid_reg      <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
      if (state_reg == HDR && accept && type_match && !s_last) rid_reg <= hdr_rid;
    end
  end

  // Two-entry FIFO: writes go to the tail slot, so the head stays put while
  // the consumer stalls; push and pop together leave occupancy unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_reg] <= push_entry;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Drop pulse lands the cycle after the discarding beat; counter saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_dropped_reg <= 1'b0;
      drop_count_reg  <= 16'd0;
    end else begin
      pkt_dropped_reg <= drop_done;
      if (drop_done && drop_count_reg != 16'hFFFF) drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign {AXIM_rid, AXIM_rdata, AXIM_rresp, AXIM_rlast} = fifo_mem[rd_ptr_reg];
  assign AXIM_ruser  = '0;
  assign AXIM_rvalid = (count_reg != 2'd0);
  assign in_progress = (state_reg == DATA) || (state_reg == DROP);
  assign pkt_dropped = pkt_dropped_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_stream_to_axi_r.sv
// Testbench for stream_to_axi_r: randomized packets checked against a
// packet-level model of expected R beats and drop counts.
module tb_stream_to_axi_r;

  localparam int DW = 128;
  localparam int IW = 32;
  localparam int UW = 64;
  localparam logic [2:0] MY_TYPE = 3'b000;

  typedef struct packed {
    logic [IW-1:0] rid;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  logic          clk;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [DW-1:0] s_data;
  logic [IW-1:0] AXIM_rid;
  logic [DW-1:0] AXIM_rdata;
  logic [1:0]    AXIM_rresp;
  logic          AXIM_rlast;
  logic [UW-1:0] AXIM_ruser;
  logic          AXIM_rvalid;
  logic          AXIM_rready;
  logic          in_progress;
  logic          pkt_dropped;
  logic [15:0]   drop_count;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    check_cnt = 0;
  int    pass_cnt = 0;
  int    exp_drops = 0;
  int    pulse_cnt = 0;
  bit    rand_rready = 0;

  stream_to_axi_r #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW),
    .STREAM_TYPE_WIDTH(3), .STREAM_TYPE(MY_TYPE)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_data(s_data),
    .AXIM_rid(AXIM_rid), .AXIM_rdata(AXIM_rdata), .AXIM_rresp(AXIM_rresp),
    .AXIM_rlast(AXIM_rlast), .AXIM_ruser(AXIM_ruser), .AXIM_rvalid(AXIM_rvalid),
    .AXIM_rready(AXIM_rready), .in_progress(in_progress),
    .pkt_dropped(pkt_dropped), .drop_count(drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs only change 2ns after a rising edge, so the falling edge sees the
  // exact values the next rising edge will use for its handshakes.
  always @(negedge clk) begin
    if (!reset) begin
      if (AXIM_rvalid && AXIM_rready) got_q.push_back({AXIM_rid, AXIM_rdata, AXIM_rresp, AXIM_rlast});
      if (pkt_dropped) pulse_cnt++;
    end
  end

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] make_hdr(input logic [2:0] typ, input logic [IW-1:0] rid);
    logic [DW-1:0] h;
    h = rand128();
    h[DW-1 -: 3] = typ;
    h[IW-1:0] = rid;
    return h;
  endfunction

  function automatic int sat_drops(input int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one beat and return just after the edge that accepts it.
  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    if (rand_rready) AXIM_rready = ($urandom_range(0, 1) == 1);
    while (!s_ready && n < 200) begin
      step();
      if (rand_rready) AXIM_rready = ($urandom_range(0, 1) == 1);
      n++;
    end
    if (!s_ready) begin
      check_cnt++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
    end
    step();
  endtask

  // Send a whole packet and record what the packet rules say must come out.
  task automatic run_packet(input logic [2:0] typ, input logic [IW-1:0] rid, input int ndata);
    logic [DW-1:0] d;
    send_beat(make_hdr(typ, rid), ndata == 0);
    if (typ == MY_TYPE) begin
      if (ndata == 0) exp_q.push_back({rid, {DW{1'b0}}, 2'b10, 1'b1});
    end else begin
      exp_drops++;
    end
    for (int i = 0; i < ndata; i++) begin
      d = rand128();
      send_beat(d, i == ndata - 1);
      if (typ == MY_TYPE) exp_q.push_back({rid, d, 2'b00, (i == ndata - 1)});
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    s_valid = 1'b0;
    rand_rready = 0;
    AXIM_rready = 1'b1;
    step();
    step();
    while (AXIM_rvalid && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = '0;
    AXIM_rready = 1'b0;
    repeat (3) step();
    check_cnt++;
    if ({s_ready, AXIM_rvalid, in_progress, pkt_dropped} !== 4'b0000)
      $display("FAIL reset_flags: s_ready/rvalid/in_progress/pkt_dropped=%b, required 0000",
               {s_ready, AXIM_rvalid, in_progress, pkt_dropped});
    else pass_cnt++;
    check_cnt++;
    if ({AXIM_rid, AXIM_rdata, AXIM_rresp, AXIM_rlast, AXIM_ruser, drop_count} !== '0)
      $display("FAIL reset_data: rid=%h rdata=%h rresp=%b rlast=%b ruser=%h drop_count=%h, required all 0",
               AXIM_rid, AXIM_rdata, AXIM_rresp, AXIM_rlast, AXIM_ruser, drop_count);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    check_cnt++;
    if (s_ready !== 1'b0) $display("FAIL reset_release_ready: s_ready=%b before first edge, required 0", s_ready);
    else pass_cnt++;
    @(posedge clk);
    #2;
    check_cnt++;
    if (s_ready !== 1'b1) $display("FAIL reset_first_edge_ready: s_ready=%b, required 1", s_ready);
    else pass_cnt++;
    $display("reset: done");
  endtask

  task automatic test_basic();
    logic [DW-1:0] d;
    AXIM_rready = 1'b1;
    send_beat(make_hdr(3'b000, 32'h5), 1'b0);
    check_cnt++;
    if ({AXIM_rvalid, in_progress} !== 2'b01)
      $display("FAIL basic_after_hdr: rvalid/in_progress=%b, required 01", {AXIM_rvalid, in_progress});
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      d = rand128();
      send_beat(d, i == 3);
      exp_q.push_back({32'h5, d, 2'b00, (i == 3)});
      if (i == 0) begin
        check_cnt++;
        if (AXIM_rvalid !== 1'b1) $display("FAIL basic_latency: rvalid=%b one cycle after D0, required 1", AXIM_rvalid);
        else pass_cnt++;
        check_cnt++;
        if (AXIM_ruser !== '0) $display("FAIL basic_ruser: ruser=%h, required 0", AXIM_ruser);
        else pass_cnt++;
      end
    end
    drain();
    check_cnt++;
    if (got_q.size() !== exp_q.size()) $display("FAIL basic_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_cnt++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL basic_beat%0d: got rid=%h rdata=%h rresp=%b rlast=%b, required rid=%h rdata=%h rresp=%b rlast=%b",
                 i, got_q[i].rid, got_q[i].data, got_q[i].resp, got_q[i].last,
                 exp_q[i].rid, exp_q[i].data, exp_q[i].resp, exp_q[i].last);
      else begin
        pass_cnt++;
        $display("basic beat %0d: rid=%h rresp=%b rlast=%b", i, got_q[i].rid, got_q[i].resp, got_q[i].last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_hdr_only();
    AXIM_rready = 1'b1;
    run_packet(3'b000, 32'h9, 0);
    drain();
    check_cnt++;
    if (got_q.size() !== 1) $display("FAIL hdr_only_count: got %0d beats, required 1", got_q.size());
    else pass_cnt++;
    if (got_q.size() > 0) begin
      check_cnt++;
      if (got_q[0] !== exp_q[0])
        $display("FAIL hdr_only_beat: got rid=%h rdata=%h rresp=%b rlast=%b, required rid=%h rdata=0 rresp=10 rlast=1",
                 got_q[0].rid, got_q[0].data, got_q[0].resp, got_q[0].last, exp_q[0].rid);
      else begin
        pass_cnt++;
        $display("hdr_only beat: rid=%h rresp=%b rlast=%b", got_q[0].rid, got_q[0].resp, got_q[0].last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_drop();
    int p0;
    int seen_valid;
    p0 = pulse_cnt;
    seen_valid = 0;
    AXIM_rready = 1'b1;
    send_beat(make_hdr(3'b101, $urandom), 1'b0);
    check_cnt++;
    if (in_progress !== 1'b1) $display("FAIL drop_in_progress: in_progress=%b after header, required 1", in_progress);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (AXIM_rvalid) seen_valid++;
      send_beat(rand128(), i == 2);
      if (AXIM_rvalid) seen_valid++;
    end
    exp_drops++;
    s_valid = 1'b0;
    check_cnt++;
    if ({pkt_dropped, in_progress} !== 2'b10)
      $display("FAIL drop_end: pkt_dropped/in_progress=%b after last beat, required 10", {pkt_dropped, in_progress});
    else pass_cnt++;
    check_cnt++;
    if (drop_count !== 16'(sat_drops(exp_drops))) $display("FAIL drop_count: drop_count=%0d, required %0d", drop_count, sat_drops(exp_drops));
    else pass_cnt++;
    step();
    step();
    check_cnt++;
    if (pulse_cnt - p0 !== 1) $display("FAIL drop_pulses: %0d pkt_dropped pulses, required 1", pulse_cnt - p0);
    else pass_cnt++;
    check_cnt++;
    if (seen_valid !== 0 || got_q.size() !== 0) $display("FAIL drop_no_rvalid: rvalid seen %0d times, required 0", seen_valid + got_q.size());
    else pass_cnt++;
    $display("drop packet: drop_count=%0d", drop_count);
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] d [5];
    logic [IW-1:0] rid;
    beat_t head;
    int bad_stable;
    rid = $urandom;
    bad_stable = 0;
    for (int i = 0; i < 5; i++) d[i] = rand128();
    AXIM_rready = 1'b0;
    send_beat(make_hdr(3'b000, rid), 1'b0);
    for (int i = 0; i < 5; i++) exp_q.push_back({rid, d[i], 2'b00, (i == 4)});
    send_beat(d[0], 1'b0);
    send_beat(d[1], 1'b0);
    s_valid = 1'b1;
    s_data  = d[2];
    s_last  = 1'b0;
    check_cnt++;
    if (s_ready !== 1'b0) $display("FAIL bp_full: s_ready=%b after 2 beats with rready=0, required 0", s_ready);
    else pass_cnt++;
    head = {AXIM_rid, AXIM_rdata, AXIM_rresp, AXIM_rlast};
    check_cnt++;
    if (head !== exp_q[0]) $display("FAIL bp_head: head rdata=%h, required %h", head.data, exp_q[0].data);
    else pass_cnt++;
    repeat (5) begin
      step();
      if (s_ready !== 1'b0 || AXIM_rvalid !== 1'b1 || {AXIM_rid, AXIM_rdata, AXIM_rresp, AXIM_rlast} !== head) bad_stable++;
    end
    check_cnt++;
    if (bad_stable !== 0) $display("FAIL bp_stable: outputs moved in %0d stalled cycles, required 0", bad_stable);
    else pass_cnt++;
    AXIM_rready = 1'b1;
    send_beat(d[2], 1'b0);
    send_beat(d[3], 1'b0);
    send_beat(d[4], 1'b1);
    drain();
    check_cnt++;
    if (got_q.size() !== exp_q.size()) $display("FAIL bp_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_cnt++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL bp_beat%0d: got rid=%h rdata=%h rlast=%b, required rid=%h rdata=%h rlast=%b",
                 i, got_q[i].rid, got_q[i].data, got_q[i].last, exp_q[i].rid, exp_q[i].data, exp_q[i].last);
      else begin
        pass_cnt++;
        $display("bp beat %0d: rdata=%h rlast=%b", i, got_q[i].data, got_q[i].last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int p0;
    int nforeign;
    int r;
    logic [2:0] typ;
    p0 = pulse_cnt;
    nforeign = 0;
    rand_rready = 1;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 3);
      if (r < 2) typ = 3'b000;
      else if (r == 2) typ = 3'b101;
      else typ = 3'($urandom_range(1, 7));
      if (typ != MY_TYPE) nforeign++;
      run_packet(typ, $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();
    check_cnt++;
    if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_cnt++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL rand_beat%0d: got rid=%h rdata=%h rresp=%b rlast=%b, required rid=%h rdata=%h rresp=%b rlast=%b",
                 i, got_q[i].rid, got_q[i].data, got_q[i].resp, got_q[i].last,
                 exp_q[i].rid, exp_q[i].data, exp_q[i].resp, exp_q[i].last);
      else begin
        pass_cnt++;
        $display("rand beat %0d: rid=%h rresp=%b rlast=%b", i, got_q[i].rid, got_q[i].resp, got_q[i].last);
      end
    end
    check_cnt++;
    if (drop_count !== 16'(sat_drops(exp_drops))) $display("FAIL rand_drop_count: drop_count=%0d, required %0d", drop_count, sat_drops(exp_drops));
    else pass_cnt++;
    check_cnt++;
    if (pulse_cnt - p0 !== nforeign) $display("FAIL rand_pulses: %0d pulses, required %0d", pulse_cnt - p0, nforeign);
    else pass_cnt++;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_packet();
    AXIM_rready = 1'b0;
    send_beat(make_hdr(3'b000, $urandom), 1'b0);
    send_beat(rand128(), 1'b0);
    send_beat(rand128(), 1'b0);
    s_data = rand128();
    reset = 1'b1;
    #1;
    check_cnt++;
    if ({s_ready, AXIM_rvalid, in_progress, AXIM_rlast, AXIM_rresp} !== 6'b0 || AXIM_rdata !== '0 || AXIM_rid !== '0 || drop_count !== 16'd0)
      $display("FAIL midreset_outputs: s_ready=%b rvalid=%b in_progress=%b rid=%h rdata=%h drop_count=%0d, required all 0",
               s_ready, AXIM_rvalid, in_progress, AXIM_rid, AXIM_rdata, drop_count);
    else pass_cnt++;
    s_valid = 1'b0;
    exp_drops = 0;
    step();
    got_q.delete();
    exp_q.delete();
    reset = 1'b0;
    step();
    AXIM_rready = 1'b1;
    run_packet(3'b000, $urandom, 3);
    drain();
    check_cnt++;
    if (got_q.size() !== exp_q.size()) $display("FAIL midreset_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_cnt++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL midreset_beat%0d: got rid=%h rdata=%h rlast=%b, required rid=%h rdata=%h rlast=%b",
                 i, got_q[i].rid, got_q[i].data, got_q[i].last, exp_q[i].rid, exp_q[i].data, exp_q[i].last);
      else begin
        pass_cnt++;
        $display("midreset beat %0d: rid=%h rlast=%b", i, got_q[i].rid, got_q[i].last);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_saturation();
    int p0;
    AXIM_rready = 1'b1;
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = make_hdr(3'b011, 32'h0);
    repeat (65535) step();
    exp_drops += 65535;
    s_valid = 1'b0;
    step();
    check_cnt++;
    if (drop_count !== 16'(sat_drops(exp_drops))) $display("FAIL sat_preload: drop_count=%h, required %h", drop_count, 16'(sat_drops(exp_drops)));
    else pass_cnt++;
    p0 = pulse_cnt;
    send_beat(make_hdr(3'b110, 32'h1), 1'b1);
    exp_drops++;
    s_valid = 1'b0;
    check_cnt++;
    if ({pkt_dropped, drop_count} !== {1'b1, 16'(sat_drops(exp_drops))})
      $display("FAIL sat_extra: pkt_dropped=%b drop_count=%h, required 1 %h", pkt_dropped, drop_count, 16'(sat_drops(exp_drops)));
    else pass_cnt++;
    step();
    check_cnt++;
    if (pulse_cnt - p0 !== 1) $display("FAIL sat_pulse: %0d pulses, required 1", pulse_cnt - p0);
    else pass_cnt++;
    $display("saturation: drop_count=%h", drop_count);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hdr_only();
    test_drop();
    test_back_pressure();
    test_random();
    test_reset_mid_packet();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
